// File: rtl/peripheral_cdc_pkg_bb.sv
// Shared types and defaults for the toggle req/ack CDC transmitter.
// Optional ack-timeout logic is enabled with CDC_TIMEOUT_EN.
package peripheral_cdc_pkg_bb;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } cdc_tx_state_t;

    localparam int CDC_SYNC_STAGES_DEF = 2;
    localparam int CDC_TIMEOUT_DEF     = 1024;

endpackage

// File: rtl/peripheral_cdc_ack_sync_bb.sv
// Reset-to-zero flop chain bringing the far-end ack toggle into clk.
module peripheral_cdc_ack_sync_bb
    import peripheral_cdc_pkg_bb::*;
#(
    parameter int SYNC_STAGES = CDC_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/peripheral_cdc_tx_bb.sv
// Source end of a 2-phase req/ack word transfer across clock domains.
// Define CDC_TIMEOUT_EN to add the sticky ack-timeout flag.
module peripheral_cdc_tx_bb
    import peripheral_cdc_pkg_bb::*;
#(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = CDC_SYNC_STAGES_DEF,
    parameter int TIMEOUT_CYC = CDC_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_req_tgl,
    input  logic              rx_ack_tgl,
    output logic              busy,
    output logic              done,
    input  logic              err_clr,
    output logic              timeout_err
);

    cdc_tx_state_t     state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              req_q, req_d;
    logic              ack_s;
    logic              ack_eq;
    logic              accept;

    peripheral_cdc_ack_sync_bb #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(rx_ack_tgl),
        .sync_o (ack_s)
    );

    // Equal toggles mean nothing is outstanding at the far end.
    assign ack_eq  = (ack_s == req_q);
    assign s_ready = (state_q == IDLE) && ack_eq;
    assign accept  = s_valid && s_ready;
    assign busy    = (state_q == WAIT_ACK);
    assign done    = busy && ack_eq;

    assign tx_data    = data_q;
    assign tx_req_tgl = req_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = s_data;
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_eq) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
        end
    end

`ifdef CDC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          err_set;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (busy && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fire once on reaching the limit so err_clr sticks while stalled.
    assign err_set = busy && (cnt_q != CNT_MAX) && (cnt_d == CNT_MAX);

    always_comb begin
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = err_clr ^ (TIMEOUT_CYC == 0);
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_peripheral_cdc_tx_bb.sv
// Randomized self-checking bench for peripheral_cdc_tx_bb.
// Covers the CDC_TIMEOUT_EN build when that macro is defined.
module tb_peripheral_cdc_tx_bb;

    localparam int SS  = 2;
    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [31:0] tx_data;
    logic        tx_req_tgl;
    logic        rx_ack_tgl;
    logic        busy;
    logic        done;
    logic        err_clr;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: toggle parity and the word currently owned by the link
    logic        m_req;
    logic [31:0] m_data;

    peripheral_cdc_tx_bb #(
        .DATA_W     (32),
        .SYNC_STAGES(SS),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .tx_data    (tx_data),
        .tx_req_tgl (tx_req_tgl),
        .rx_ack_tgl (rx_ack_tgl),
        .busy       (busy),
        .done       (done),
        .err_clr    (err_clr),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic hold_checks();
        chk("hold_data", tx_data, m_data);
        chk("hold_req", tx_req_tgl, m_req);
        chk("hold_busy", busy, 1'b1);
        chk("hold_ready", s_ready, 1'b0);
    endtask

    // One full transfer; far end echoes after ack_dly cycles.
    task automatic send(input logic [31:0] w,
                        input int ack_dly,
                        input bit hold,
                        input logic [31:0] nxt);
        int guard;
        s_valid = 1'b1;
        s_data  = w;
        guard   = 0;
        while (!s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_wait", s_ready, 1'b1);
        @(negedge clk);
        m_req  = ~m_req;
        m_data = w;
        chk("acc_req", tx_req_tgl, m_req);
        chk("acc_data", tx_data, w);
        chk("acc_busy", busy, 1'b1);
        chk("acc_ready", s_ready, 1'b0);
        chk("acc_done", done, 1'b0);
        if (hold) begin
            s_data = nxt;
        end else begin
            s_valid = 1'b0;
            s_data  = $urandom;
        end
        for (int i = 0; i < ack_dly; i++) begin
            if (!hold) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = $urandom;
            end
            @(negedge clk);
            hold_checks();
            chk("wait_done", done, 1'b0);
        end
        if (!hold) s_valid = 1'b0;
        rx_ack_tgl = m_req;
        for (int k = 1; k <= SS; k++) begin
            @(negedge clk);
            hold_checks();
            chk("done_time", done, (k == SS));
        end
        @(negedge clk);
        chk("post_done", done, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_ready", s_ready, 1'b1);
        chk("post_data", tx_data, m_data);
    endtask

    initial begin
        logic [31:0] cur;
        logic [31:0] nxt;
        bit          h;

        rst        = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        rx_ack_tgl = 1'b0;
        err_clr    = 1'b0;
        m_req      = 1'b0;
        m_data     = '0;
        repeat (3) @(negedge clk);
        chk("rst_data", tx_data, 32'h0);
        chk("rst_req", tx_req_tgl, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_tmo", timeout_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        send(32'hA5A5_0001, 3, 1'b0, 32'h0);

        send(32'h1, 4, 1'b1, 32'h2);
        send(32'h2, 2, 1'b0, 32'h0);

        cur = $urandom;
        for (int i = 0; i < 25; i++) begin
            h   = (i < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
            nxt = $urandom;
            send(cur, $urandom_range(0, 6), h, nxt);
            cur = h ? nxt : $urandom;
        end

        // Reset while waiting for ack
        s_valid = 1'b1;
        s_data  = $urandom;
        @(negedge clk);
        s_valid = 1'b0;
        chk("mid_busy", busy, 1'b1);
        repeat (2) @(negedge clk);
        rst        = 1'b1;
        rx_ack_tgl = 1'b0;
        m_req      = 1'b0;
        m_data     = '0;
        #1;
        chk("mid_req", tx_req_tgl, 1'b0);
        chk("mid_data", tx_data, 32'h0);
        chk("mid_busy0", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (SS + 1) @(negedge clk);
        chk("mid_ready", s_ready, 1'b1);

        // Stale ack present at reset release
        rst        = 1'b1;
        rx_ack_tgl = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (SS + 1) @(negedge clk);
        s_valid = 1'b1;
        s_data  = $urandom;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stale_ready", s_ready, 1'b0);
            chk("stale_done", done, 1'b0);
            chk("stale_busy", busy, 1'b0);
        end
        chk("stale_data", tx_data, 32'h0);
        chk("stale_req", tx_req_tgl, 1'b0);
        s_valid    = 1'b0;
        rx_ack_tgl = 1'b0;
        for (int k = 1; k <= SS; k++) begin
            @(negedge clk);
            chk("stale_clear", s_ready, (k == SS));
        end

        // Stall with no ack
        s_valid = 1'b1;
        s_data  = $urandom;
        @(negedge clk);
        s_valid = 1'b0;
        m_req   = ~m_req;
        chk("stall_busy", busy, 1'b1);
`ifdef CDC_TIMEOUT_EN
        chk("tmo_k0", timeout_err, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            chk("tmo_set", timeout_err, (k >= TMO));
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("tmo_clr", timeout_err, 1'b0);
        repeat (5) @(negedge clk);
        chk("tmo_stays", timeout_err, 1'b0);
`else
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (k % 100 == 0) err_clr = ~err_clr;
            chk("no_tmo", timeout_err, 1'b0);
        end
        err_clr = 1'b0;
`endif
        chk("stall_busy2", busy, 1'b1);
        rx_ack_tgl = m_req;
        for (int k = 1; k <= SS; k++) begin
            @(negedge clk);
            chk("late_done", done, (k == SS));
        end
        @(negedge clk);
        chk("late_ready", s_ready, 1'b1);
        chk("late_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
